// File: rtl/arena_engine.sv
// arena_engine: light-cycle game engine owning the tile map, stepping players,
// resolving collisions and serving a registered renderer read port.
module arena_engine #(
  parameter int MAP_WIDTH   = 64,
  parameter int MAP_HEIGHT  = 48,
  parameter int NUM_PLAYERS = 2,
  localparam int XW = $clog2(MAP_WIDTH),
  localparam int YW = $clog2(MAP_HEIGHT),
  localparam int TW = $clog2(NUM_PLAYERS + 2),
  localparam int WW = $clog2(NUM_PLAYERS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     tick,
  input  logic [3*NUM_PLAYERS-1:0] dir_in,
  input  logic [XW-1:0]            rd_x,
  input  logic [YW-1:0]            rd_y,
  output logic [TW-1:0]            rd_tile,
  output logic                     busy,
  output logic [NUM_PLAYERS-1:0]   alive,
  output logic                     round_over,
  output logic [WW-1:0]            winner
);
  localparam int CELLS = MAP_WIDTH * MAP_HEIGHT;
  localparam int AW = $clog2(CELLS);
  localparam int PW = NUM_PLAYERS > 1 ? $clog2(NUM_PLAYERS) : 1;
  localparam logic [XW:0] WX = (XW+1)'(MAP_WIDTH);
  localparam logic [YW:0] HY = (YW+1)'(MAP_HEIGHT);
  localparam logic [XW-1:0] XMAX = XW'(MAP_WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(MAP_HEIGHT - 1);
  localparam logic [YW-1:0] YHOME = YW'(MAP_HEIGHT / 2);
  localparam logic [PW-1:0] PLAST = PW'(NUM_PLAYERS - 1);
  localparam logic [2:0] WAIT = 3'd0, RIGHT = 3'd1, LEFT = 3'd2, UP = 3'd3, DOWN = 3'd4;

  typedef enum logic [2:0] {IDLE, CLEAR, PLACE, RUN, TARGET, STEP_RD, STEP_WR, RESOLVE} state_t;
  state_t state, state_nx;

  logic [TW-1:0] mem [CELLS];
  logic [XW-1:0] cx, px;
  logic [YW-1:0] cy;
  logic [XW-1:0] hx [NUM_PLAYERS];
  logic [XW-1:0] tx [NUM_PLAYERS];
  logic [YW-1:0] hy [NUM_PLAYERS];
  logic [YW-1:0] ty [NUM_PLAYERS];
  logic [2:0] hd [NUM_PLAYERS];
  logic [2:0] nh [NUM_PLAYERS];
  logic [XW:0] nx [NUM_PLAYERS];
  logic [YW:0] ny [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] live, mov, clash, oob, mov_c, clash_c, oob_c;
  logic [PW-1:0] pi;
  logic [TW-1:0] step_tile, wdata;
  logic [AW-1:0] waddr, taddr;
  logic [WW-1:0] cnt, win_c;
  logic we, last_cell, blocked, over;

  function automatic logic [AW-1:0] addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(y) * AW'(MAP_WIDTH) + AW'(x);
  endfunction

  function automatic logic [2:0] rev(input logic [2:0] h);
    return h == RIGHT ? LEFT : h == LEFT ? RIGHT : h == UP ? DOWN : h == DOWN ? UP : WAIT;
  endfunction

  // next heading and target per player; players aiming at the same cell both die
  always_comb begin
    mov_c = '0;
    clash_c = '0;
    oob_c = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      nh[p] = (dir_in[3*p +: 3] == WAIT || dir_in[3*p +: 3] > DOWN || dir_in[3*p +: 3] == rev(hd[p])) ? hd[p] : dir_in[3*p +: 3];
      nx[p] = {1'b0, hx[p]} + (XW+1)'(nh[p] == RIGHT) - (XW+1)'(nh[p] == LEFT);
      ny[p] = {1'b0, hy[p]} + (YW+1)'(nh[p] == DOWN) - (YW+1)'(nh[p] == UP);
      mov_c[p] = live[p] && nh[p] != WAIT;
      oob_c[p] = nx[p] >= WX || ny[p] >= HY;
    end
    for (int p = 0; p < NUM_PLAYERS; p++)
      for (int q = 0; q < NUM_PLAYERS; q++)
        if (p != q && mov_c[p] && mov_c[q] && nx[p] == nx[q] && ny[p] == ny[q]) clash_c[p] = 1'b1;
  end

  always_comb begin
    px = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      if (pi == PW'(p)) px = XW'((p + 1) * MAP_WIDTH / (NUM_PLAYERS + 1));
    last_cell = cx == XMAX && cy == YMAX;
    taddr = oob[pi] ? '0 : addr(tx[pi], ty[pi]);
    blocked = oob[pi] || clash[pi] || step_tile != '0;
    we = state == CLEAR || state == PLACE || (state == STEP_WR && mov[pi] && !blocked);
    waddr = state == CLEAR ? addr(cx, cy) : state == PLACE ? addr(px, YHOME) : taddr;
    wdata = state == CLEAR ? ((cx == '0 || cx == XMAX || cy == '0 || cy == YMAX) ? TW'(1) : '0) : TW'(pi) + TW'(2);
    cnt = '0;
    win_c = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      if (live[p]) begin
        cnt = cnt + WW'(1);
        win_c = WW'(p + 1);
      end
    over = NUM_PLAYERS > 1 ? cnt <= WW'(1) : cnt == '0;
  end

  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   state_nx = last_cell ? PLACE : CLEAR;
      PLACE:   state_nx = pi == PLAST ? RUN : PLACE;
      RUN:     state_nx = tick ? TARGET : RUN;
      TARGET:  state_nx = STEP_RD;
      STEP_RD: state_nx = STEP_WR;
      STEP_WR: state_nx = pi == PLAST ? RESOLVE : STEP_RD;
      RESOLVE: state_nx = over ? IDLE : RUN;
      default: state_nx = state;
    endcase
    if (start) state_nx = CLEAR;
    busy = state != IDLE && state != RUN;
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      alive <= '0;
      live <= '0;
      round_over <= 1'b0;
      winner <= '0;
      cx <= '0;
      cy <= '0;
      pi <= '0;
    end else begin
      case (state)
        CLEAR: begin
          cx <= cx == XMAX ? '0 : cx + 1'b1;
          cy <= cx == XMAX ? cy + 1'b1 : cy;
        end
        PLACE: begin
          hx[pi] <= px;
          hy[pi] <= YHOME;
          hd[pi] <= WAIT;
          pi <= pi + 1'b1;
          if (pi == PLAST) begin
            alive <= '1;
            live <= '1;
          end
        end
        TARGET: begin
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            hd[p] <= nh[p];
            tx[p] <= nx[p][XW-1:0];
            ty[p] <= ny[p][YW-1:0];
          end
          mov <= mov_c;
          clash <= clash_c;
          oob <= oob_c;
          pi <= '0;
        end
        STEP_RD: step_tile <= mem[taddr];
        STEP_WR: begin
          if (mov[pi] && blocked) live[pi] <= 1'b0;
          if (mov[pi] && !blocked) begin
            hx[pi] <= tx[pi];
            hy[pi] <= ty[pi];
          end
          pi <= pi + 1'b1;
        end
        RESOLVE: begin
          alive <= live;
          round_over <= over;
          winner <= over && cnt == WW'(1) ? win_c : '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;

  // reads of a cell written in the same cycle see the old contents
  always_ff @(posedge clk)
    rd_tile <= rst ? '0 : ({1'b0, rd_x} < WX && {1'b0, rd_y} < HY) ? mem[addr(rd_x, rd_y)] : '0;
endmodule
